// File: rtl/assoc_cache.sv
// Set-associative, write-through, no-write-allocate cache in front of a word-wide memory.
//
// Ports:
//   clk, reset            - sole clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   - request handshake; req_write, req_address, req_write_data describe it
//   flush                 - invalidate every line (only while idle, wins over a pending request)
//   resp_valid            - one-cycle completion pulse, with resp_read_data and resp_miss
//   mem_req/mem_we        - memory transfer request, held with address/data until mem_ack
//   mem_address, mem_write_data, mem_ack, mem_read_data - memory word interface
module assoc_cache #(
  parameter int unsigned RAM_ADDRESS_BITS   = 10,
  parameter int unsigned CACHE_ADDRESS_BITS = 5,
  parameter int unsigned DATA_BITS          = 32,
  parameter int unsigned ASOC_BITS          = 1,
  parameter int unsigned BLOCK_BITS         = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [RAM_ADDRESS_BITS-1:0] req_address,
  input  logic [DATA_BITS-1:0]        req_write_data,
  input  logic                        flush,
  output logic                        resp_valid,
  output logic [DATA_BITS-1:0]        resp_read_data,
  output logic                        resp_miss,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [RAM_ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_BITS-1:0]        mem_write_data,
  input  logic                        mem_ack,
  input  logic [DATA_BITS-1:0]        mem_read_data
);

  localparam int unsigned WAYS       = 2**ASOC_BITS;
  localparam int unsigned WORDS      = 2**BLOCK_BITS;
  localparam int unsigned INDEX_BITS = CACHE_ADDRESS_BITS - ASOC_BITS - BLOCK_BITS;
  localparam int unsigned SETS       = 2**INDEX_BITS;
  localparam int unsigned TAG_BITS   = RAM_ADDRESS_BITS - INDEX_BITS - BLOCK_BITS;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOOKUP    = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;
  localparam logic [1:0] WRITE_MEM = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [RAM_ADDRESS_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0]        wdata_q;
  logic                        write_q;
  logic                        miss_q;     // sticky: this read already went through a refill
  logic                        hit_q;      // lookup result of a write, reported at completion
  logic [BLOCK_BITS-1:0]       counter_q;
  logic [ASOC_BITS-1:0]        victim_q;

  logic [WAYS-1:0]      valid_q [SETS];
  logic [TAG_BITS-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_BITS-1:0] data_q  [SETS][WAYS][WORDS];
  logic [ASOC_BITS-1:0] rr_q    [SETS];

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [BLOCK_BITS-1:0] req_offset;

  assign req_tag    = addr_q[RAM_ADDRESS_BITS-1 -: TAG_BITS];
  assign req_index  = addr_q[BLOCK_BITS +: INDEX_BITS];
  assign req_offset = addr_q[BLOCK_BITS-1:0];

  logic                 hit;
  logic [ASOC_BITS-1:0] hit_way;
  logic [DATA_BITS-1:0] hit_word;
  logic                 free_found;
  logic [ASOC_BITS-1:0] free_way;

  // Tag compare over the addressed set, plus the lowest-numbered invalid way for refills.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    hit_word   = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_index][ASOC_BITS'(w)] &&
          tag_q[req_index][ASOC_BITS'(w)] == req_tag) begin
        hit      = 1'b1;
        hit_way  = ASOC_BITS'(w);
        hit_word = data_q[req_index][ASOC_BITS'(w)][req_offset];
      end
      if (!free_found && !valid_q[req_index][ASOC_BITS'(w)]) begin
        free_found = 1'b1;
        free_way   = ASOC_BITS'(w);
      end
    end
  end

  // Outputs and next state; everything is forced low while reset is asserted.
  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_read_data = '0;
    resp_miss      = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          req_ready = !flush;
          if (req_valid && !flush) state_d = LOOKUP;
        end
        LOOKUP: begin
          if (write_q) begin
            state_d = WRITE_MEM;
          end else if (hit) begin
            resp_valid     = 1'b1;
            resp_read_data = hit_word;
            resp_miss      = miss_q;
            state_d        = IDLE;
          end else begin
            state_d = REFILL;
          end
        end
        REFILL: begin
          mem_req     = 1'b1;
          mem_address = {req_tag, req_index, counter_q};
          if (mem_ack && counter_q == BLOCK_BITS'(WORDS - 1)) state_d = LOOKUP;
        end
        default: begin // WRITE_MEM
          mem_req        = 1'b1;
          mem_we         = 1'b1;
          mem_address    = addr_q;
          mem_write_data = wdata_q;
          if (mem_ack) begin
            resp_valid = 1'b1;
            resp_miss  = !hit_q;
            state_d    = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      miss_q    <= 1'b0;
      hit_q     <= 1'b0;
      counter_q <= '0;
      victim_q  <= '0;
      valid_q   <= '{default: '0};
      rr_q      <= '{default: '0};
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (flush) begin
            valid_q <= '{default: '0};
          end else if (req_valid) begin
            addr_q  <= req_address;
            wdata_q <= req_write_data;
            write_q <= req_write;
          end
        end
        LOOKUP: begin
          if (write_q) begin
            hit_q <= hit;
          end else if (hit) begin
            miss_q <= 1'b0;
          end else begin
            counter_q <= '0;
            if (free_found) begin
              victim_q <= free_way;
            end else begin
              victim_q             <= rr_q[req_index];
              rr_q[req_index]      <= rr_q[req_index] + 1'b1;
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            counter_q <= counter_q + 1'b1;
            if (counter_q == BLOCK_BITS'(WORDS - 1)) begin
              tag_q[req_index][victim_q]   <= req_tag;
              valid_q[req_index][victim_q] <= 1'b1;
              miss_q                       <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data arrays carry no reset; an aborted refill leaves its line invalid anyway.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == LOOKUP && write_q && hit) begin
        data_q[req_index][hit_way][req_offset] <= wdata_q;
      end
      if (state_q == REFILL && mem_ack) begin
        data_q[req_index][victim_q][counter_q] <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
module tb_assoc_cache;

  typedef struct packed {
    logic [31:0] data;
    logic        miss;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, flush;
  logic [9:0]  req_address;
  logic [31:0] req_write_data;
  logic        resp_valid, resp_miss;
  logic [31:0] resp_read_data;
  logic        mem_req, mem_we, mem_ack;
  logic [9:0]  mem_address;
  logic [31:0] mem_write_data, mem_read_data;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int acc_cycle = 0;
  int resp_count = 0;
  int ack_delay = 0;

  exp_t        exp_q [$];
  xfer_t       mem_log [$];
  logic [31:0] mem_model [1024];

  assoc_cache dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_write_data (req_write_data),
    .flush          (flush),
    .resp_valid     (resp_valid),
    .resp_read_data (resp_read_data),
    .resp_miss      (resp_miss),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_ack        (mem_ack),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    #1;
    if (resp_valid) resp_count++;
  end

  // Memory model: acks after ack_delay waiting cycles and checks that a pending request is held.
  int          wait_cnt = 0;
  bit          hold_valid = 0;
  xfer_t       hold;
  always @(negedge clk) begin
    if (mem_req) begin
      if (hold_valid) begin
        checks++;
        if (mem_we !== hold.we || mem_address !== hold.addr || mem_write_data !== hold.data) begin
          failures++;
          $display("FAIL mem_hold got we=%b addr=%h data=%h exp we=%b addr=%h data=%h",
                   mem_we, mem_address, mem_write_data, hold.we, hold.addr, hold.data);
        end
      end
      if (wait_cnt >= ack_delay) begin
        mem_ack       = 1'b1;
        mem_read_data = mem_model[mem_address];
        if (mem_we) mem_model[mem_address] = mem_write_data;
        mem_log.push_back('{we: mem_we, addr: mem_address, data: mem_write_data});
        wait_cnt   = 0;
        hold_valid = 0;
      end else begin
        mem_ack    = 1'b0;
        wait_cnt++;
        hold_valid = 1;
        hold       = '{we: mem_we, addr: mem_address, data: mem_write_data};
      end
    end else begin
      mem_ack    = 1'b0;
      wait_cnt   = 0;
      hold_valid = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic wr, input logic [9:0] a, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_write = wr; req_address = a; req_write_data = wd;
    @(posedge clk);
    #1;
    acc_cycle = cycle;
    req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_write_data = '0;
  endtask

  task automatic await_resp(output exp_t got, output int lat, output bit to);
    got = '0; lat = 0; to = 1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (resp_valid) begin
        got = '{data: resp_read_data, miss: resp_miss};
        lat = cycle - acc_cycle + 1;
        to  = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, mem_req, mem_we, resp_miss} !== 5'b0 ||
        resp_read_data !== 32'h0 || mem_address !== 10'h0 || mem_write_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b rv=%b mreq=%b we=%b miss=%b exp all zero",
               req_ready, resp_valid, mem_req, mem_we, resp_miss);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_cold_read();
    exp_t got, e; int lat; bit to;
    mem_log.delete();
    exp_q.push_back('{data: 32'hA2, miss: 1'b1});
    issue(1'b0, 10'h04E, '0);
    await_resp(got, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || got !== e) begin
      failures++;
      $display("FAIL cold_read_resp got=%h/%b to=%0d exp=%h/%b", got.data, got.miss, to, e.data, e.miss);
    end
    checks++;
    if (mem_log.size() != 4) begin
      failures++;
      $display("FAIL cold_read_xfers got=%0d exp=4", mem_log.size());
    end
    for (int i = 0; i < 4 && i < mem_log.size(); i++) begin
      checks++;
      if (mem_log[i].we !== 1'b0 || mem_log[i].addr !== 10'(10'h04C + i)) begin
        failures++;
        $display("FAIL cold_read_addr%0d got we=%b addr=%h exp we=0 addr=%h",
                 i, mem_log[i].we, mem_log[i].addr, 10'(10'h04C + i));
      end
    end
    mem_log.delete();
    exp_q.push_back('{data: 32'hA2, miss: 1'b0});
    issue(1'b0, 10'h04E, '0);
    await_resp(got, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || got !== e) begin
      failures++;
      $display("FAIL reread_resp got=%h/%b to=%0d exp=%h/%b", got.data, got.miss, to, e.data, e.miss);
    end
    checks++;
    if (lat != 1 || mem_log.size() != 0) begin
      failures++;
      $display("FAIL reread_latency got lat=%0d xfers=%0d exp lat=1 xfers=0", lat, mem_log.size());
    end
  endtask

  task automatic test_write_hit();
    exp_t got, e; int lat; bit to;
    mem_log.delete();
    exp_q.push_back('{data: 32'h0, miss: 1'b0});
    issue(1'b1, 10'h04D, 32'h55);
    await_resp(got, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || got !== e) begin
      failures++;
      $display("FAIL write_hit_resp got=%h/%b to=%0d exp=%h/%b", got.data, got.miss, to, e.data, e.miss);
    end
    checks++;
    if (mem_log.size() != 1 || mem_log[0] !== '{we: 1'b1, addr: 10'h04D, data: 32'h55}) begin
      failures++;
      $display("FAIL write_hit_xfer got n=%0d first=%h exp n=1 first=%h", mem_log.size(),
               (mem_log.size() > 0) ? mem_log[0] : '0, xfer_t'{we: 1'b1, addr: 10'h04D, data: 32'h55});
    end
    mem_log.delete();
    exp_q.push_back('{data: 32'h55, miss: 1'b0});
    issue(1'b0, 10'h04D, '0);
    await_resp(got, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || got !== e || mem_log.size() != 0) begin
      failures++;
      $display("FAIL write_hit_readback got=%h/%b to=%0d xfers=%0d exp=%h/%b xfers=0",
               got.data, got.miss, to, mem_log.size(), e.data, e.miss);
    end
  endtask

  task automatic test_flush();
    exp_t got, e; int lat; bit to;
    mem_log.delete();
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_address = 10'h04E;
    exp_q.push_back('{data: 32'hA2, miss: 1'b1});
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready got=%b exp=0", req_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_after_ready got=%b exp=1", req_ready);
    end
    @(posedge clk);
    #1;
    acc_cycle = cycle;
    req_valid = 1'b0; req_address = '0;
    await_resp(got, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || got !== e || mem_log.size() != 4) begin
      failures++;
      $display("FAIL flush_read got=%h/%b to=%0d xfers=%0d exp=%h/%b xfers=4",
               got.data, got.miss, to, mem_log.size(), e.data, e.miss);
    end
  endtask

  task automatic test_evict();
    logic [9:0] addrs [7];
    bit         misses [7];
    exp_t got, e; int lat; bit to;
    addrs  = '{10'h000, 10'h010, 10'h020, 10'h010, 10'h000, 10'h020, 10'h010};
    misses = '{1, 1, 1, 0, 1, 0, 1};
    for (int i = 0; i < 7; i++) begin
      mem_log.delete();
      exp_q.push_back('{data: mem_model[addrs[i]], miss: misses[i]});
      issue(1'b0, addrs[i], '0);
      await_resp(got, lat, to);
      e = exp_q.pop_front();
      checks++;
      if (to || got !== e || mem_log.size() != (misses[i] ? 4 : 0)) begin
        failures++;
        $display("FAIL evict_step%0d addr=%h got=%h/%b to=%0d xfers=%0d exp=%h/%b xfers=%0d",
                 i, addrs[i], got.data, got.miss, to, mem_log.size(), e.data, e.miss,
                 misses[i] ? 4 : 0);
      end
    end
  endtask

  task automatic test_write_miss();
    exp_t got, e; int lat; bit to;
    ack_delay = 1;
    mem_log.delete();
    exp_q.push_back('{data: 32'h0, miss: 1'b1});
    issue(1'b1, 10'h1F0, 32'h77);
    await_resp(got, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || got !== e || mem_log.size() != 1) begin
      failures++;
      $display("FAIL write_miss_resp got=%h/%b to=%0d xfers=%0d exp=%h/%b xfers=1",
               got.data, got.miss, to, mem_log.size(), e.data, e.miss);
    end
    mem_log.delete();
    exp_q.push_back('{data: 32'h77, miss: 1'b1});
    issue(1'b0, 10'h1F0, '0);
    await_resp(got, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || got !== e || mem_log.size() != 4) begin
      failures++;
      $display("FAIL write_miss_read got=%h/%b to=%0d xfers=%0d exp=%h/%b xfers=4",
               got.data, got.miss, to, mem_log.size(), e.data, e.miss);
    end
    ack_delay = 0;
  endtask

  task automatic test_reset_abort();
    exp_t got, e; int lat; bit to;
    int rc;
    int n = 0;
    mem_log.delete();
    rc = resp_count;
    issue(1'b0, 10'h2B4, '0);
    while (mem_log.size() < 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_reset got mreq=%b rv=%b ready=%b exp 0/0/0", mem_req, resp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_after_reset got mreq=%b ready=%b exp 0/1", mem_req, req_ready);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (resp_count != rc) begin
      failures++;
      $display("FAIL abort_no_resp got=%0d exp=%0d", resp_count - rc, 0);
    end
    mem_log.delete();
    exp_q.push_back('{data: mem_model[10'h2B4], miss: 1'b1});
    issue(1'b0, 10'h2B4, '0);
    await_resp(got, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || got !== e || mem_log.size() != 4) begin
      failures++;
      $display("FAIL abort_reread got=%h/%b to=%0d xfers=%0d exp=%h/%b xfers=4",
               got.data, got.miss, to, mem_log.size(), e.data, e.miss);
    end
  endtask

  task automatic test_back_to_back();
    logic       wrs   [3];
    logic [9:0] addrs [3];
    exp_t       exps  [3];
    exp_t got, e; int lat; bit to;
    ack_delay = 2;
    wrs   = '{1'b0, 1'b1, 1'b0};
    addrs = '{10'h2B4, 10'h2B5, 10'h2B5};
    exps  = '{'{data: mem_model[10'h2B4], miss: 1'b0}, '{data: 32'h0, miss: 1'b0},
              '{data: 32'hBEEF, miss: 1'b0}};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exps[i]);
      issue(wrs[i], addrs[i], 32'hBEEF);
      await_resp(got, lat, to);
      e = exp_q.pop_front();
      checks++;
      if (to || got !== e || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_step%0d got=%h/%b to=%0d ready=%b exp=%h/%b ready=0",
                 i, got.data, got.miss, to, req_ready, e.data, e.miss);
      end
    end
    ack_delay = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'hC0DE_0000 | i;
    for (int k = 0; k < 4; k++) mem_model[10'h04C + k] = 32'hA0 + k;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0;
    req_write_data = '0; flush = 1'b0; mem_ack = 1'b0; mem_read_data = '0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_flush();
    test_evict();
    test_write_miss();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 RAM_ADDRESS_BITS, 10, word-address width.
REQ-002 CACHE_ADDRESS_BITS, 5, log2 of cache capacity in words.
REQ-003 DATA_BITS, 32, word width.
REQ-004 ASOC_BITS, 1, log2 of ways per set.
REQ-005 BLOCK_BITS, 2, log2 of words per line.
REQ-006 Derived values SHALL be computed with 2**n:
- WAYS = 2**ASOC_BITS.
- WORDS = 2**BLOCK_BITS.
- INDEX_BITS = CACHE_ADDRESS_BITS-ASOC_BITS-BLOCK_BITS.
- SETS = 2**INDEX_BITS.
- TAG_BITS = RAM_ADDRESS_BITS-INDEX_BITS-BLOCK_BITS.
REQ-007 Address split SHALL be {tag, index, offset}, MSB to LSB.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 req_valid  in  1  request present.
REQ-011 req_ready  out  1  request accepted when req_valid & req_ready.
REQ-012 req_write  in  1  1 = write, 0 = read.
REQ-013 req_address  in  RAM_ADDRESS_BITS  word address.
REQ-014 req_write_data  in  DATA_BITS  write data.
REQ-015 flush  in  1  invalidate all lines; honoured only in IDLE.
REQ-016 resp_valid  out  1  one-cycle completion pulse per accepted request.
REQ-017 resp_read_data  out  DATA_BITS  read data; 0 for writes.
REQ-018 resp_miss  out  1  request took a miss path; qualified by resp_valid.
REQ-019 mem_req  out  1  memory transaction pending.
REQ-020 mem_we  out  1  1 = memory write.
REQ-021 mem_address  out  RAM_ADDRESS_BITS  memory word address.
REQ-022 mem_write_data  out  DATA_BITS  memory write data.
REQ-023 mem_ack  in  1  completes the current word transfer; ignored while mem_req=0.
REQ-024 mem_read_data  in  DATA_BITS  valid in the mem_ack cycle of a read.

Function
REQ-025 The FSM SHALL have states IDLE, LOOKUP, REFILL, WRITE_MEM.
REQ-026 IDLE behaviour:
- req_ready=1; all other outputs are 0.
- Accept: latch address, data and type, then go to LOOKUP.
- flush=1 with req_valid=0: clear all valid bits in one cycle and stay in IDLE.
- flush=1 with req_valid=1: flush takes priority and req_ready=0.
REQ-027 LOOKUP SHALL last exactly one cycle:
- Hit = some way with valid=1 and a matching tag.
- Reset state guarantees at most one way hits.
REQ-028 Read hit:
- resp_valid=1 and resp_read_data=word in the LOOKUP cycle, then IDLE.
- Latency is 1 cycle after acceptance.
REQ-029 Read miss SHALL go to REFILL with word counter = 0; the victim is chosen at this point.
REQ-030 Victim selection:
- Use the lowest-index invalid way.
- If all ways are valid, use way rr_ptr[index].
- On replacing a valid line, rr_ptr[index] increments modulo WAYS.
REQ-031 REFILL behaviour:
- mem_req=1, mem_we=0, mem_address={tag, index, counter}.
- Each mem_ack writes mem_read_data into victim word[counter], then increments counter.
REQ-032 On the ack of word WORDS-1, REFILL SHALL:
- Set the victim tag and valid bit.
- Set the sticky miss flag.
- Return to LOOKUP, which then hits and responds with resp_miss=1.
REQ-033 Write, hit or miss, is write-through with no write-allocate:
- A hit updates the cached word in the LOOKUP cycle.
- A miss leaves the cache unchanged.
- Then go to WRITE_MEM.
REQ-034 WRITE_MEM behaviour:
- mem_req=1, mem_we=1, mem_address=latched address, mem_write_data=latched data.
- On mem_ack: resp_valid=1 in the same cycle, resp_miss = inverse of the LOOKUP hit result, then IDLE.
REQ-035 mem_req SHALL hold stable, with stable address and data, until mem_ack; mem_ack may arrive in the same cycle mem_req first rises.
REQ-036 Back-to-back operation: the next request SHALL be accepted no earlier than the cycle after resp_valid.
REQ-037 Exactly one resp_valid SHALL be produced per accepted request; requests are never dropped except by reset.

Reset
REQ-038 While reset is sampled high, the block SHALL:
- Go to IDLE.
- Clear all valid bits, rr_ptr, the counter and the miss flag.
- Drive every output to 0, including req_ready.
REQ-039 The first cycle after reset deasserts SHALL present req_ready=1.
REQ-040 Reset during REFILL or WRITE_MEM SHALL:
- Abort the operation and drop mem_req at that edge.
- Never produce resp_valid for the aborted request.
- Not reset the data arrays.

Verification (default parameters: 4 sets, 2 ways, 4 words/line, 6-bit tag)
REQ-041 Cold read 0x04E, memory returns 0xA0-0xA3 for 0x04C-0x04F:
- Response: four reads at 0x04C..0x04F, then resp_read_data=0xA2, resp_miss=1.
- Re-read 0x04E: response 1 cycle after acceptance with 0xA2, resp_miss=0, mem_req never rises.
REQ-042 After REQ-041, write 0x04D=0x55, then read 0x04D:
- The write issues one memory write (0x04D, 0x55) with resp_miss=0.
- The read hits and returns 0x55.
REQ-043 Write 0x1F0=0x77 on a cold cache, then read 0x1F0:
- The write produces a memory write with resp_miss=1 and no refill.
- The read then misses and refills.
REQ-044 Read 0x000, 0x010, 0x020 (all index 0), then 0x010 and 0x000:
- 0x020 evicts way 0.
- 0x010 hits.
- 0x000 misses and evicts way 1.
REQ-045 Reset asserted after 2 refill acks, then read of the same address:
- mem_req=0 after the reset edge and no resp_valid.
- The read refills all 4 words again.
REQ-046 flush in IDLE after REQ-041, then read 0x04E:
- req_ready=0 during the flush cycle.
- The read misses.
